// File: rtl/fpu_mul_param.sv
// Iterative IEEE-754 binary multiplier for any EXPW/FRACW format.
// Radix-2 shift-add significand product, then normalise, round-to-nearest-even and special-value override.
module fpu_mul_param #(
    parameter int EXPW  = 5,
    parameter int FRACW = 10
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [EXPW+FRACW:0] fpuIn1,
    input  logic [EXPW+FRACW:0] fpuIn2,
    output logic                busy,
    output logic                done,
    output logic [EXPW+FRACW:0] fpuOut,
    output logic [3:0]          condCodes,
    output logic [4:0]          opStatusFlags
);
    localparam int W    = 1 + EXPW + FRACW;
    localparam int SW   = FRACW + 1;
    localparam int PW   = 2 * SW;
    localparam int BIAS = (1 << (EXPW - 1)) - 1;
    localparam int MAXE = (1 << EXPW) - 1;
    localparam int EW   = EXPW + 2;
    localparam int CW   = $clog2(FRACW + 1);
    localparam int SHW  = $clog2(PW + 1);
    localparam int NW   = EW + SHW + 2;

    // Handshake: start is only looked at in IDLE or DONE; done is high for the single DONE cycle.
    typedef enum logic [1:0] {IDLE, MUL, NORM, DONE} state_t;
    state_t state, nextState;

    logic [SW-1:0]        mcand;
    logic [PW-1:0]        prod;
    logic [CW-1:0]        cnt;
    logic signed [EW-1:0] expSum;
    logic                 resSign;
    logic                 specHit, specHitQ;
    logic                 specInv, specInvQ;
    logic [W-1:0]         specRes, specResQ;

    logic                 accept;
    logic [EXPW-1:0]      exp1, exp2, eff1, eff2;
    logic [FRACW-1:0]     frac1, frac2;
    logic [SW-1:0]        sig1, sig2;
    logic                 nan1, nan2, snan1, snan2, inf1, inf2, zero1, zero2, sgn;
    logic [SW:0]          mulSum;

    assign accept = start && (state == IDLE || state == DONE);
    assign busy   = (state == MUL) || (state == NORM);
    assign done   = (state == DONE);

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (start) nextState = MUL;
            MUL:     if (cnt == '0) nextState = NORM;
            NORM:    nextState = DONE;
            DONE:    nextState = start ? MUL : IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    // Operand decode and special-value classification, used on the accepting edge.
    always_comb begin
        exp1  = fpuIn1[W-2:FRACW];
        exp2  = fpuIn2[W-2:FRACW];
        frac1 = fpuIn1[FRACW-1:0];
        frac2 = fpuIn2[FRACW-1:0];
        sig1  = {exp1 != '0, frac1};
        sig2  = {exp2 != '0, frac2};
        eff1  = (exp1 == '0) ? EXPW'(1) : exp1;
        eff2  = (exp2 == '0) ? EXPW'(1) : exp2;
        nan1  = (&exp1) && (frac1 != '0);
        nan2  = (&exp2) && (frac2 != '0);
        snan1 = nan1 && !frac1[FRACW-1];
        snan2 = nan2 && !frac2[FRACW-1];
        inf1  = (&exp1) && (frac1 == '0);
        inf2  = (&exp2) && (frac2 == '0);
        zero1 = (exp1 == '0) && (frac1 == '0);
        zero2 = (exp2 == '0) && (frac2 == '0);
        sgn   = fpuIn1[W-1] ^ fpuIn2[W-1];

        specHit = 1'b0;
        specInv = 1'b0;
        specRes = '0;
        if (nan1 || nan2 || (inf1 && zero2) || (zero1 && inf2)) begin
            specHit = 1'b1;
            specInv = snan1 || snan2 || (inf1 && zero2) || (zero1 && inf2);
            specRes = {1'b0, {EXPW{1'b1}}, 1'b1, {(FRACW-1){1'b0}}};
        end else if (inf1 || inf2) begin
            specHit = 1'b1;
            specRes = {sgn, {EXPW{1'b1}}, {FRACW{1'b0}}};
        end else if (zero1 || zero2) begin
            specHit = 1'b1;
            specRes = {sgn, {(W-1){1'b0}}};
        end
    end

    // Multiplier sits in the low half of prod and shifts out LSB first as partial sums enter the top.
    assign mulSum = {1'b0, prod[PW-1:SW]} + (prod[0] ? {1'b0, mcand} : {(SW+1){1'b0}});

    logic [SHW-1:0]       lzc, shClamp;
    logic [PW-1:0]        normMant, mant;
    logic [2*PW-1:0]      wide;
    logic signed [NW-1:0] expSx, eNorm, shAmt, eBase, eFinal;
    logic                 tiny, lostBits, guardB, roundB, stickyB, roundUp, inexact, ovf;
    logic [SW:0]          rounded;
    logic [FRACW-1:0]     fracFinal;
    logic [W-1:0]         resOut;
    logic [4:0]           resFlags;
    logic [3:0]           resCc;

    always_comb begin
        lzc = SHW'(PW);
        for (int i = 0; i < PW; i++) begin
            if (prod[i]) lzc = SHW'(PW - 1 - i);
        end
        normMant = prod << lzc;
        // Leading one now sits at bit PW-1, which has weight 2^1 relative to expSum.
        expSx = {{(NW-EW){expSum[EW-1]}}, expSum};
        eNorm = expSx + NW'(1) - NW'(lzc);
        tiny  = (eNorm < 1);
        shAmt = NW'(1) - eNorm;
        shClamp = (shAmt > NW'(PW)) ? SHW'(PW) : shAmt[SHW-1:0];
        wide  = {normMant, {PW{1'b0}}} >> shClamp;
        if (tiny) begin
            mant     = wide[2*PW-1:PW];
            lostBits = |wide[PW-1:0];
            eBase    = '0;
        end else begin
            mant     = normMant;
            lostBits = 1'b0;
            eBase    = eNorm;
        end
        guardB  = mant[SW-1];
        roundB  = mant[SW-2];
        stickyB = (|mant[SW-3:0]) | lostBits;
        inexact = guardB | roundB | stickyB;
        roundUp = guardB & (roundB | stickyB | mant[SW]);
        rounded = {1'b0, mant[PW-1:SW]} + (SW+1)'(roundUp);
        // A carry out of a subnormal lands on the hidden bit and becomes the minimum normal.
        eFinal  = eBase + NW'(rounded[SW]) + NW'(tiny & rounded[SW-1]);
        ovf     = (eFinal >= NW'(MAXE));
        fracFinal = rounded[SW] ? rounded[SW-1:1] : rounded[FRACW-1:0];

        if (specHitQ) begin
            resOut   = specResQ;
            resFlags = {specInvQ, 4'b0000};
        end else if (ovf) begin
            resOut   = {resSign, {EXPW{1'b1}}, {FRACW{1'b0}}};
            resFlags = 5'b00101;
        end else begin
            resOut   = {resSign, eFinal[EXPW-1:0], fracFinal};
            resFlags = {3'b000, tiny & inexact, inexact};
        end
        resCc = {resOut[W-2:0] == '0, 1'b0, resOut[W-1], resFlags[2]};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mcand         <= '0;
            prod          <= '0;
            cnt           <= '0;
            expSum        <= '0;
            resSign       <= 1'b0;
            specHitQ      <= 1'b0;
            specInvQ      <= 1'b0;
            specResQ      <= '0;
            fpuOut        <= '0;
            condCodes     <= '0;
            opStatusFlags <= '0;
        end else begin
            if (accept) begin
                mcand    <= sig1;
                prod     <= {{SW{1'b0}}, sig2};
                cnt      <= CW'(FRACW);
                expSum   <= EW'(eff1) + EW'(eff2) - EW'(BIAS);
                resSign  <= sgn;
                specHitQ <= specHit;
                specInvQ <= specInv;
                specResQ <= specRes;
            end else if (state == MUL) begin
                prod <= {mulSum, prod[SW-1:1]};
                cnt  <= cnt - CW'(1);
            end
            if (state == NORM) begin
                fpuOut        <= resOut;
                condCodes     <= resCc;
                opStatusFlags <= resFlags;
            end
        end
    end
endmodule

// File: tb/tb_fpu_mul_param.sv
// Directed bench for fpu_mul_param: fp16 and fp32 instances sharing clock and reset.
// Expected results are hand-computed IEEE-754 products.
module tb_fpu_mul_param;
    logic clock = 1'b0;
    logic reset = 1'b1;

    logic        start16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [15:0] out16;
    logic [3:0]  cc16;
    logic [4:0]  fl16;
    logic        busy16, done16;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic [31:0] out32;
    logic [3:0]  cc32;
    logic [4:0]  fl32;
    logic        busy32, done32;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clock = ~clock;

    fpu_mul_param #(.EXPW(5), .FRACW(10)) u16 (
        .clock(clock), .reset(reset), .start(start16),
        .fpuIn1(a16), .fpuIn2(b16),
        .busy(busy16), .done(done16), .fpuOut(out16),
        .condCodes(cc16), .opStatusFlags(fl16)
    );

    fpu_mul_param #(.EXPW(8), .FRACW(23)) u32 (
        .clock(clock), .reset(reset), .start(start32),
        .fpuIn1(a32), .fpuIn2(b32),
        .busy(busy32), .done(done32), .fpuOut(out32),
        .condCodes(cc32), .opStatusFlags(fl32)
    );

    // Driver: one fp16 operation; lat counts edges from the accepting edge (1) to the done edge.
    task automatic do_op16(input logic [15:0] a, input logic [15:0] b,
                           output int lat, output int busyCnt, output logic doneAfter);
        @(negedge clock);
        a16 = a; b16 = b; start16 = 1'b1;
        @(posedge clock); #1;
        start16 = 1'b0;
        lat = 1;
        busyCnt = int'(busy16);
        while (!done16 && lat < 60) begin
            @(posedge clock); #1;
            lat++;
            if (busy16) busyCnt++;
        end
        @(posedge clock); #1;
        doneAfter = done16;
    endtask

    task automatic do_op32(input logic [31:0] a, input logic [31:0] b, output int lat);
        @(negedge clock);
        a32 = a; b32 = b; start32 = 1'b1;
        @(posedge clock); #1;
        start32 = 1'b0;
        lat = 1;
        while (!done32 && lat < 80) begin
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        #12;
        nChecks++; if ({out16, fl16, cc16, busy16, done16} !== '0) begin nFails++; $display("FAIL reset16 got out=%h fl=%b cc=%b busy=%b done=%b want all 0", out16, fl16, cc16, busy16, done16); end
        nChecks++; if ({out32, fl32, cc32, busy32, done32} !== '0) begin nFails++; $display("FAIL reset32 got out=%h fl=%b cc=%b busy=%b done=%b want all 0", out32, fl32, cc32, busy32, done32); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_basic_fp16();
        int lat, bc;
        logic da;
        do_op16(16'h3E00, 16'h4000, lat, bc, da);
        nChecks++; if (lat !== 13) begin nFails++; $display("FAIL basic_latency got %0d want 13", lat); end
        nChecks++; if (bc !== 12) begin nFails++; $display("FAIL basic_busy_cycles got %0d want 12", bc); end
        nChecks++; if (da !== 1'b0) begin nFails++; $display("FAIL basic_done_width got done=%b after pulse want 0", da); end
        nChecks++; if (out16 !== 16'h4200) begin nFails++; $display("FAIL basic_out got %h want 4200", out16); end
        nChecks++; if (fl16 !== 5'b00000) begin nFails++; $display("FAIL basic_flags got %b want 00000", fl16); end
        nChecks++; if (cc16 !== 4'b0000) begin nFails++; $display("FAIL basic_cc got %b want 0000", cc16); end
    endtask

    task automatic test_round_overflow();
        int lat, bc;
        logic da;
        do_op16(16'h3C01, 16'h3C01, lat, bc, da);
        nChecks++; if (out16 !== 16'h3C02) begin nFails++; $display("FAIL round_out got %h want 3C02", out16); end
        nChecks++; if (fl16 !== 5'b00001) begin nFails++; $display("FAIL round_flags got %b want 00001", fl16); end
        do_op16(16'h7BFF, 16'h4000, lat, bc, da);
        nChecks++; if (out16 !== 16'h7C00) begin nFails++; $display("FAIL ovf_out got %h want 7C00", out16); end
        nChecks++; if (fl16 !== 5'b00101) begin nFails++; $display("FAIL ovf_flags got %b want 00101", fl16); end
        nChecks++; if (cc16 !== 4'b0001) begin nFails++; $display("FAIL ovf_cc got %b want 0001", cc16); end
    endtask

    task automatic test_specials();
        int lat, bc;
        logic da;
        do_op16(16'h7C00, 16'h0000, lat, bc, da);
        nChecks++; if (out16 !== 16'h7E00) begin nFails++; $display("FAIL infzero_out got %h want 7E00", out16); end
        nChecks++; if (fl16 !== 5'b10000) begin nFails++; $display("FAIL infzero_flags got %b want 10000", fl16); end
        nChecks++; if (lat !== 13) begin nFails++; $display("FAIL infzero_latency got %0d want 13", lat); end
        do_op16(16'h0001, 16'h3800, lat, bc, da);
        nChecks++; if (out16 !== 16'h0000) begin nFails++; $display("FAIL tie_even_out got %h want 0000", out16); end
        nChecks++; if (fl16 !== 5'b00011) begin nFails++; $display("FAIL tie_even_flags got %b want 00011", fl16); end
        nChecks++; if (cc16 !== 4'b1000) begin nFails++; $display("FAIL tie_even_cc got %b want 1000", cc16); end
        do_op16(16'h8400, 16'h3800, lat, bc, da);
        nChecks++; if (out16 !== 16'h8200) begin nFails++; $display("FAIL subnorm_out got %h want 8200", out16); end
        nChecks++; if (fl16 !== 5'b00000) begin nFails++; $display("FAIL subnorm_flags got %b want 00000", fl16); end
        nChecks++; if (cc16 !== 4'b0010) begin nFails++; $display("FAIL subnorm_cc got %b want 0010", cc16); end
        do_op16(16'h7D00, 16'h3C00, lat, bc, da);
        nChecks++; if ({out16, fl16} !== {16'h7E00, 5'b10000}) begin nFails++; $display("FAIL snan got out=%h fl=%b want 7E00 10000", out16, fl16); end
        do_op16(16'h7E00, 16'h0000, lat, bc, da);
        nChecks++; if ({out16, fl16} !== {16'h7E00, 5'b00000}) begin nFails++; $display("FAIL qnan_zero got out=%h fl=%b want 7E00 00000", out16, fl16); end
        do_op16(16'hFC00, 16'h4000, lat, bc, da);
        nChecks++; if ({out16, fl16, cc16} !== {16'hFC00, 5'b00000, 4'b0010}) begin nFails++; $display("FAIL neg_inf got out=%h fl=%b cc=%b want FC00 00000 0010", out16, fl16, cc16); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] opA [3];
        logic [15:0] opB [3];
        logic [15:0] expOut [3];
        logic [3:0]  expCc [3];
        int gap;
        opA = '{16'h3E00, 16'h4000, 16'hC000};
        opB = '{16'h4000, 16'h4000, 16'h3C00};
        expOut = '{16'h4200, 16'h4400, 16'hC000};
        expCc = '{4'b0000, 4'b0000, 4'b0010};
        @(negedge clock);
        a16 = opA[0]; b16 = opB[0]; start16 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            gap = 0;
            do begin
                @(posedge clock); #1;
                gap++;
                if (gap == 1) begin
                    nChecks++; if (done16 !== 1'b0) begin nFails++; $display("FAIL b2b_done_width op%0d got done=%b want 0", k, done16); end
                    if (k < 2) begin a16 = opA[k+1]; b16 = opB[k+1]; end
                    else start16 = 1'b0;
                end
            end while (!done16 && gap < 60);
            nChecks++; if (gap !== 13) begin nFails++; $display("FAIL b2b_spacing op%0d got %0d want 13", k, gap); end
            nChecks++; if ({out16, cc16} !== {expOut[k], expCc[k]}) begin nFails++; $display("FAIL b2b_result op%0d got %h/%b want %h/%b", k, out16, cc16, expOut[k], expCc[k]); end
        end
        @(posedge clock); #1;
        nChecks++; if (done16 !== 1'b0) begin nFails++; $display("FAIL b2b_idle got done=%b want 0", done16); end
    endtask

    task automatic test_mid_start();
        int lat;
        int extra;
        @(negedge clock);
        a16 = 16'h4200; b16 = 16'h4200; start16 = 1'b1;
        @(posedge clock); #1;
        start16 = 1'b0;
        lat = 1;
        repeat (4) begin @(posedge clock); #1; lat++; end
        @(negedge clock);
        a16 = 16'h3C00; b16 = 16'h3C00; start16 = 1'b1;
        @(posedge clock); #1;
        start16 = 1'b0;
        lat++;
        while (!done16 && lat < 60) begin @(posedge clock); #1; lat++; end
        nChecks++; if (lat !== 13) begin nFails++; $display("FAIL mid_start_latency got %0d want 13", lat); end
        nChecks++; if ({out16, fl16} !== {16'h4880, 5'b00000}) begin nFails++; $display("FAIL mid_start_out got %h/%b want 4880/00000", out16, fl16); end
        extra = 0;
        repeat (20) begin @(posedge clock); #1; if (done16) extra++; end
        nChecks++; if (extra !== 0) begin nFails++; $display("FAIL mid_start_extra_done got %0d want 0", extra); end
    endtask

    task automatic test_reset_midop();
        int lat, bc, extra;
        logic da;
        @(negedge clock);
        a16 = 16'h4400; b16 = 16'h4000; start16 = 1'b1;
        @(posedge clock); #1;
        start16 = 1'b0;
        repeat (4) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        nChecks++; if ({out16, fl16, cc16, busy16, done16} !== '0) begin nFails++; $display("FAIL midop_reset got out=%h fl=%b cc=%b busy=%b done=%b want all 0", out16, fl16, cc16, busy16, done16); end
        repeat (2) @(negedge clock);
        reset = 1'b0;
        extra = 0;
        repeat (20) begin @(posedge clock); #1; if (done16) extra++; end
        nChecks++; if (extra !== 0) begin nFails++; $display("FAIL midop_no_done got %0d dones want 0", extra); end
        do_op16(16'h4400, 16'h4000, lat, bc, da);
        nChecks++; if (lat !== 13) begin nFails++; $display("FAIL post_reset_latency got %0d want 13", lat); end
        nChecks++; if (out16 !== 16'h4800) begin nFails++; $display("FAIL post_reset_out got %h want 4800", out16); end
    endtask

    task automatic test_fp32();
        int lat;
        do_op32(32'h3FC00000, 32'h40000000, lat);
        nChecks++; if (lat !== 26) begin nFails++; $display("FAIL fp32_latency got %0d want 26", lat); end
        nChecks++; if ({out32, fl32, cc32} !== {32'h40400000, 5'b00000, 4'b0000}) begin nFails++; $display("FAIL fp32_mul got %h/%b/%b want 40400000/00000/0000", out32, fl32, cc32); end
        do_op32(32'h00000001, 32'h3F000000, lat);
        nChecks++; if ({out32, fl32, cc32} !== {32'h00000000, 5'b00011, 4'b1000}) begin nFails++; $display("FAIL fp32_underflow got %h/%b/%b want 00000000/00011/1000", out32, fl32, cc32); end
    endtask

    initial begin
        test_reset();
        test_basic_fp16();
        test_round_overflow();
        test_specials();
        test_back_to_back();
        test_mid_start();
        test_reset_midop();
        test_fp32();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end
endmodule
